// File: rtl/grid_pkg.sv
// grid_pkg
// Shared definitions for the game-world cell store:
//   - default grid dimensions and coordinate width
//   - cell encodings (empty / food / snake / wall)
//   - controller state type
//   - helper that returns the number of cells in a grid
package grid_pkg;

   localparam int DEF_GRID_W  = 15;
   localparam int DEF_GRID_H  = 15;
   localparam int DEF_CELL_W  = 2;
   localparam int DEF_COORD_W = 4;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_FOOD  = 2'b01;
   localparam logic [1:0] CELL_SNAKE = 2'b10;
   localparam logic [1:0] CELL_WALL  = 2'b11;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   function automatic int cell_count(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/grid_addr.sv
// grid_addr
// Combinational 0-based (x, y) to linear cell address conversion.
// Ports:
//   x, y      in  COORD_W  column / row
//   addr      out ADDR_W   y*GRID_W + x, forced to 0 when out of range
//   in_range  out 1        x < GRID_W and y < GRID_H
module grid_addr
   import grid_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int COORD_W = DEF_COORD_W,
   parameter int ADDR_W  = $clog2(GRID_W * GRID_H)
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [ADDR_W-1:0]  addr,
   output logic               in_range
);

   // The product is formed at ADDR_W+COORD_W bits, wide enough that even
   // the largest out-of-range coordinates cannot wrap into a valid address.
   localparam int WIDE_W = ADDR_W + COORD_W;
   localparam logic [WIDE_W-1:0] W_LIM = WIDE_W'(GRID_W);
   localparam logic [WIDE_W-1:0] H_LIM = WIDE_W'(GRID_H);
   localparam logic [WIDE_W-1:0] N_LIM = WIDE_W'(cell_count(GRID_W, GRID_H));

   logic [WIDE_W-1:0] x_wide;
   logic [WIDE_W-1:0] y_wide;
   logic [WIDE_W-1:0] lin;

   // The final bound on the linear address is implied by the x/y checks;
   // it is kept so the whole wide result participates in the decision.
   always_comb begin
      x_wide   = WIDE_W'(x);
      y_wide   = WIDE_W'(y);
      lin      = y_wide * W_LIM + x_wide;
      in_range = (x_wide < W_LIM) && (y_wide < H_LIM) && (lin < N_LIM);
      addr     = in_range ? lin[ADDR_W-1:0] : '0;
   end

endmodule

// File: rtl/grid_ram.sv
// grid_ram
// GRID_W x GRID_H cell store shared by the game logic and the VGA renderer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   clr_req / busy           start a clear sweep / sweep in progress
//   vga_x, vga_y, vga_data   registered read port, 1-cycle latency
//   sw_req, sw_we, sw_x, sw_y, sw_wdata
//                            handshaked game access (held until sw_ack)
//   sw_ack, sw_rdata, sw_err one-cycle acknowledge, old cell content,
//                            out-of-range flag
module grid_ram
   import grid_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int CELL_W  = DEF_CELL_W,
   parameter int COORD_W = DEF_COORD_W,
   parameter logic [CELL_W-1:0] INIT_CELL = CELL_W'(CELL_EMPTY)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_req,
   output logic               busy,
   input  logic [COORD_W-1:0] vga_x,
   input  logic [COORD_W-1:0] vga_y,
   output logic [CELL_W-1:0]  vga_data,
   input  logic               sw_req,
   input  logic               sw_we,
   input  logic [COORD_W-1:0] sw_x,
   input  logic [COORD_W-1:0] sw_y,
   input  logic [CELL_W-1:0]  sw_wdata,
   output logic               sw_ack,
   output logic [CELL_W-1:0]  sw_rdata,
   output logic               sw_err
);

   localparam int N_CELLS = cell_count(GRID_W, GRID_H);
   localparam int ADDR_W  = $clog2(N_CELLS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

   logic [CELL_W-1:0] mem [0:N_CELLS-1];

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] ptr;

   logic [ADDR_W-1:0] vga_addr;
   logic              vga_in_range;
   logic [ADDR_W-1:0] sw_addr;
   logic              sw_in_range;

   logic              clr_we;
   logic              sw_accept;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [CELL_W-1:0] mem_wdata;

   grid_addr #(
      .GRID_W  (GRID_W),
      .GRID_H  (GRID_H),
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W)
   ) u_vga_addr (
      .x        (vga_x),
      .y        (vga_y),
      .addr     (vga_addr),
      .in_range (vga_in_range)
   );

   grid_addr #(
      .GRID_W  (GRID_W),
      .GRID_H  (GRID_H),
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W)
   ) u_sw_addr (
      .x        (sw_x),
      .y        (sw_y),
      .addr     (sw_addr),
      .in_range (sw_in_range)
   );

   // Next-state logic. A clear request in IDLE wins over a game request
   // presented in the same cycle; the game request simply waits.
   always_comb begin
      state_nx  = state;
      clr_we    = 1'b0;
      sw_accept = 1'b0;
      unique case (state)
         CLEAR: begin
            clr_we = 1'b1;
            if (ptr == LAST_ADDR) begin
               state_nx = IDLE;
            end
         end
         IDLE: begin
            if (clr_req) begin
               state_nx = CLEAR;
            end else if (sw_req) begin
               sw_accept = 1'b1;
            end
         end
         default: state_nx = CLEAR;
      endcase
   end

   // State register and sweep pointer; the pointer is rearmed to 0 on
   // every entry into CLEAR so a sweep always covers the whole array.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) begin
            ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
         end else if (state_nx == CLEAR) begin
            ptr <= '0;
         end
      end
   end

   assign busy = (state == CLEAR);

   // Single write port: the sweep and the game writer never coincide
   // because they belong to different states.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr;
      mem_wdata = INIT_CELL;
      if (!rst) begin
         if (clr_we) begin
            mem_we = 1'b1;
         end else if (sw_accept && sw_we && sw_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = sw_addr;
            mem_wdata = sw_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Registered read ports. Both sample the array before this edge's
   // write lands, which gives read-before-write on the game port and the
   // old value on a same-cell VGA collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_ack   <= 1'b0;
         sw_err   <= 1'b0;
         sw_rdata <= '0;
         vga_data <= '0;
      end else begin
         sw_ack   <= sw_accept;
         sw_err   <= sw_accept && !sw_in_range;
         sw_rdata <= (sw_accept && sw_in_range) ? mem[sw_addr] : '0;
         if (!vga_in_range) begin
            vga_data <= '0;
         end else if (state == CLEAR) begin
            vga_data <= INIT_CELL;
         end else begin
            vga_data <= mem[vga_addr];
         end
      end
   end

endmodule

// File: tb/tb_grid_ram.sv
// tb_grid_ram
// Directed bench for grid_ram at default parameters (15x15, 2-bit cells).
// A small array model tracks the expected cell contents for VGA scans.
module tb_grid_ram;

   import grid_pkg::*;

   localparam int LIMIT = 400;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr_req;
   logic       busy;
   logic [3:0] vga_x;
   logic [3:0] vga_y;
   logic [1:0] vga_data;
   logic       sw_req;
   logic       sw_we;
   logic [3:0] sw_x;
   logic [3:0] sw_y;
   logic [1:0] sw_wdata;
   logic       sw_ack;
   logic [1:0] sw_rdata;
   logic       sw_err;

   int checks = 0;
   int fails  = 0;

   logic [1:0] exp_mem [0:14][0:14];

   grid_ram dut (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .vga_x    (vga_x),
      .vga_y    (vga_y),
      .vga_data (vga_data),
      .sw_req   (sw_req),
      .sw_we    (sw_we),
      .sw_x     (sw_x),
      .sw_y     (sw_y),
      .sw_wdata (sw_wdata),
      .sw_ack   (sw_ack),
      .sw_rdata (sw_rdata),
      .sw_err   (sw_err)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic model_clear();
      for (int yy = 0; yy < 15; yy++)
         for (int xx = 0; xx < 15; xx++)
            exp_mem[yy][xx] = CELL_EMPTY;
   endtask

   // One game access, optionally with clr_req raised in the first cycle.
   // Returns the number of clocks until sw_ack was seen (LIMIT on timeout).
   task automatic apply_stimulus(input logic we, input logic [3:0] x,
                                 input logic [3:0] y, input logic [1:0] wdata,
                                 input logic with_clr, output int waited,
                                 output logic [1:0] rdata, output logic err);
      sw_req   = 1'b1;
      sw_we    = we;
      sw_x     = x;
      sw_y     = y;
      sw_wdata = wdata;
      clr_req  = with_clr;
      waited   = 0;
      rdata    = 2'b00;
      err      = 1'b0;
      while (waited < LIMIT) begin
         step();
         waited++;
         clr_req = 1'b0;
         if (sw_ack) begin
            rdata = sw_rdata;
            err   = sw_err;
            break;
         end
      end
      sw_req = 1'b0;
      sw_we  = 1'b0;
   endtask

   task automatic vga_read(input logic [3:0] x, input logic [3:0] y,
                           output logic [1:0] data);
      vga_x = x;
      vga_y = y;
      step();
      data = vga_data;
   endtask

   // Full VGA scan against the model, folded into a single comparison.
   task automatic vga_scan(input string tag);
      int         bad;
      logic [1:0] d;
      bad = 0;
      for (int yy = 0; yy < 15; yy++) begin
         for (int xx = 0; xx < 15; xx++) begin
            vga_read(4'(xx), 4'(yy), d);
            if (d !== exp_mem[yy][xx]) bad++;
         end
      end
      check_output(tag, bad, 0);
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < LIMIT) begin
         cnt++;
         step();
      end
   endtask

   initial begin
      int         waited;
      int         cnt;
      logic [1:0] rdata;
      logic       err;
      logic [1:0] d;

      rst      = 1'b1;
      clr_req  = 1'b0;
      vga_x    = 4'd0;
      vga_y    = 4'd0;
      sw_req   = 1'b0;
      sw_we    = 1'b0;
      sw_x     = 4'd0;
      sw_y     = 4'd0;
      sw_wdata = 2'b00;
      model_clear();

      // Reset and the power-up clear sweep.
      step();
      check_output("rst_busy", busy, 1'b1);
      check_output("rst_ack", sw_ack, 1'b0);
      check_output("rst_err", sw_err, 1'b0);
      check_output("rst_rdata", sw_rdata, 2'b00);
      check_output("rst_vga", vga_data, 2'b00);
      rst = 1'b0;
      count_busy(cnt);
      check_output("busy_len", cnt, 225);
      vga_scan("scan_after_reset");

      // Write then read (3,3).
      apply_stimulus(1'b1, 4'd3, 4'd3, CELL_FOOD, 1'b0, waited, rdata, err);
      exp_mem[3][3] = CELL_FOOD;
      check_output("wr33_lat", waited, 1);
      check_output("wr33_rdata", rdata, 2'b00);
      check_output("wr33_err", err, 1'b0);
      step();
      check_output("ack_pulse", sw_ack, 1'b0);
      apply_stimulus(1'b0, 4'd3, 4'd3, 2'b00, 1'b0, waited, rdata, err);
      check_output("rd33_rdata", rdata, CELL_FOOD);
      check_output("rd33_err", err, 1'b0);
      vga_read(4'd3, 4'd3, d);
      check_output("vga33", d, CELL_FOOD);

      // Back-to-back writes to the last cell.
      apply_stimulus(1'b1, 4'd14, 4'd14, CELL_SNAKE, 1'b0, waited, rdata, err);
      check_output("wr1414a_rdata", rdata, 2'b00);
      apply_stimulus(1'b1, 4'd14, 4'd14, CELL_WALL, 1'b0, waited, rdata, err);
      exp_mem[14][14] = CELL_WALL;
      check_output("wr1414b_rdata", rdata, CELL_SNAKE);
      vga_read(4'd14, 4'd14, d);
      check_output("vga1414", d, CELL_WALL);

      // Out-of-range accesses.
      apply_stimulus(1'b1, 4'd15, 4'd0, CELL_WALL, 1'b0, waited, rdata, err);
      check_output("oor_wr_lat", waited, 1);
      check_output("oor_wr_err", err, 1'b1);
      check_output("oor_wr_rdata", rdata, 2'b00);
      apply_stimulus(1'b0, 4'd0, 4'd15, 2'b00, 1'b0, waited, rdata, err);
      check_output("oor_rd_err", err, 1'b1);
      check_output("oor_rd_rdata", rdata, 2'b00);
      vga_read(4'd15, 4'd0, d);
      check_output("vga_oor", d, 2'b00);
      vga_scan("scan_after_oor");

      // Clear request, then a game read held through the whole sweep.
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      check_output("clr_busy", busy, 1'b1);
      model_clear();
      apply_stimulus(1'b0, 4'd3, 4'd3, 2'b00, 1'b0, waited, rdata, err);
      check_output("held_req_wait", waited, 226);
      check_output("held_req_rdata", rdata, 2'b00);
      vga_scan("scan_after_clr");

      // Clear and write requested together: the clear goes first.
      apply_stimulus(1'b1, 4'd5, 4'd5, CELL_FOOD, 1'b0, waited, rdata, err);
      apply_stimulus(1'b1, 4'd3, 4'd3, CELL_WALL, 1'b1, waited, rdata, err);
      exp_mem[3][3] = CELL_WALL;
      check_output("clr_sw_wait", waited, 227);
      check_output("clr_sw_rdata", rdata, 2'b00);
      vga_scan("scan_after_clr_sw");

      // Reset in the middle of a sweep restarts it from address 0.
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 100; i++) step();
      check_output("mid_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_output("mid_rst_busy", busy, 1'b1);
      count_busy(cnt);
      check_output("mid_busy_len", cnt, 225);
      model_clear();
      vga_scan("scan_after_mid_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/grid_ram.md
Name: grid_ram

Overview:
Parametrised successor to the game-world cell store. Holds a GRID_W x GRID_H array of CELL_W-bit cells (empty/food/snake/wall) between the game logic and the VGA renderer.
Adds over the previous generation:
- 0-based coordinates with range checking
- a registered VGA read port
- a handshaked game port that returns the old cell content on every access (collision detection)
- a hardware clear sequencer with a busy flag, run after reset and on request

Parameters:
GRID_W, 15, grid columns
GRID_H, 15, grid rows
CELL_W, 2, bits per cell
COORD_W, 4, width of x/y coordinate inputs
INIT_CELL, 0, value written to every cell by a clear sweep
ADDR_W (localparam), $clog2(GRID_W*GRID_H), linear address width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
clr_req  in  1  pulse: start a clear sweep
busy  out  1  clear sweep in progress
vga_x  in  COORD_W  VGA read column, 0-based
vga_y  in  COORD_W  VGA read row, 0-based
vga_data  out  CELL_W  registered cell value
sw_req  in  1  game-port request, held until sw_ack
sw_we  in  1  1 = write sw_wdata, 0 = read only
sw_x  in  COORD_W  game-port column, 0-based
sw_y  in  COORD_W  game-port row, 0-based
sw_wdata  in  CELL_W  write data
sw_ack  out  1  one-cycle acknowledge
sw_rdata  out  CELL_W  cell content before this access
sw_err  out  1  valid with sw_ack: coordinate out of range

Behaviour:
- Address mapping: addr = y*GRID_W + x, computed at ADDR_W+COORD_W bits so there is no overflow.
- In range means x < GRID_W and y < GRID_H. Out-of-range accesses never touch memory.
- FSM states: CLEAR, IDLE.
- Reset, on the rst cycle:
  - state = CLEAR, clear pointer = 0, busy = 1
  - sw_ack = 0, sw_err = 0, sw_rdata = 0, vga_data = 0
  - rst asserted during a sweep restarts it at address 0.
- CLEAR state:
  - Each cycle writes INIT_CELL to mem[ptr] and increments ptr.
  - On the edge that writes address GRID_W*GRID_H-1, go to IDLE; busy = 0 from the next cycle.
  - busy is high for exactly GRID_W*GRID_H cycles after rst is released (225 at defaults).
  - sw_req is not acked; the requester keeps holding it.
  - clr_req is ignored.
  - vga_data reads INIT_CELL.
- IDLE state, clr_req = 1:
  - go to CLEAR with ptr = 0 next edge.
  - clr_req takes priority over a simultaneous sw_req, which is not acked that cycle.
- IDLE state, sw_req = 1 with clr_req = 0:
  - The access is accepted at this edge.
  - Next cycle: sw_ack = 1, sw_rdata = the cell value before the edge (read-before-write).
  - If sw_we = 1 and in range, mem[addr] <= sw_wdata at the same edge.
  - Out of range: sw_ack = 1, sw_err = 1, sw_rdata = 0, no write.
- Throughput: sw_ack is a single-cycle pulse. A requester that keeps sw_req high after sw_ack gets a new access every cycle; the requester deasserts on the ack cycle to avoid a repeat.
- VGA port:
  - 1-cycle latency: vga_data <= mem[vga addr] at each edge, valid every cycle.
  - Out of range returns 0.
  - A same-cycle game write to the same cell gives the VGA port the old value.
- Memory is single-write. The clear writer and the game writer are mutually exclusive by state.

Decomposition:
- Shared package grid_pkg holds:
  - cell encodings CELL_EMPTY=2'b00, CELL_FOOD=2'b01, CELL_SNAKE=2'b10, CELL_WALL=2'b11
  - state typedef {CLEAR, IDLE}
  - default grid dimensions
- Sub-module grid_addr: combinational coordinate-to-address conversion plus in-range flag. Instantiated twice, once for the VGA port and once for the game port.

Test Plan:
- rst for 1 cycle, then release -> busy high for exactly 225 cycles; afterwards a VGA read of every cell returns 2'b00.
- Game write (x=3,y=3,wdata=01), then a game read of the same cell -> first ack sw_rdata=00; second ack sw_rdata=01 with sw_err=0; VGA (3,3) returns 01 one cycle after it is presented.
- Write 10 at (14,14), then write 11 at (14,14) -> second ack returns sw_rdata=10; mem holds 11; VGA at addr 224 reads 11.
- Write at (15,0), and separately read at (0,15) -> sw_ack=1, sw_err=1, sw_rdata=0; no cell changes (full VGA scan unchanged); VGA (15,0) returns 0.
- sw_req held during a clr_req sweep -> no ack for 225 cycles, then ack with sw_rdata=00; clr_req and sw_req asserted together in IDLE -> clear runs and sw is acked only after busy falls.
- Assert rst at ptr=100 mid-sweep -> sweep restarts, busy high for a further 225 cycles after release.
